// File: rtl/subtractor_serial_pkg.sv
// Shared constants for the serial arithmetic blocks: FSM encodings, the
// default operand width, and the per-bit borrow-path equations.
package subtractor_serial_pkg;

   localparam int SER_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_SHIFT = 2'd1,
      SER_DONE  = 2'd2
   } ser_state_e;

   // Difference bit of a single-bit subtraction a - b - br.
   function automatic logic ser_diff_bit(input logic a, input logic b, input logic br);
      return a ^ b ^ br;
   endfunction

   // Borrow-out of a single-bit subtraction a - b - br.
   function automatic logic ser_borrow_bit(input logic a, input logic b, input logic br);
      return (~a & b) | (~(a ^ b) & br);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, bo = borrow-out.
// Borrow-path counterpart of the full adder cell.
module full_subtractor
   import subtractor_serial_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = ser_diff_bit(a, b, bi);
   assign bo = ser_borrow_bit(a, b, bi);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: computes A - B - Bi one bit per clock, LSB first.
// Operands are captured on acceptance of start; D/Bo are updated together
// on the edge that processes the MSB and are announced by a one-cycle done.
module subtractor_serial
   import subtractor_serial_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bo
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [WIDTH-1:0]  a_q,     a_d;
   logic [WIDTH-1:0]  b_q,     b_d;
   logic              br_q,    br_d;
   logic [WIDTH-1:0]  acc_q,   acc_d;
   logic [WIDTH-1:0]  res_q,   res_d;
   logic              bo_q,    bo_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   logic              fs_d_s;
   logic              fs_bo_s;
   logic [WIDTH-1:0]  acc_shift_s;

   // Per-bit logic always looks at the current LSBs and the running borrow.
   full_subtractor u_fs (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .bi (br_q),
      .d  (fs_d_s),
      .bo (fs_bo_s)
   );

   // New difference bit enters at the MSB so the LSB ends up at bit 0.
   assign acc_shift_s = {fs_d_s, acc_q[WIDTH-1:1]};

   // Next-state, datapath and output-flag computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      acc_d   = acc_q;
      res_d   = res_q;
      bo_d    = bo_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         SER_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               br_d    = Bi;
               cnt_d   = {CNT_W{1'b0}};
               acc_d   = {WIDTH{1'b0}};
               state_d = SER_SHIFT;
               busy_d  = 1'b1;
            end else begin
               state_d = SER_IDLE;
            end
         end

         SER_SHIFT: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            br_d  = fs_bo_s;
            acc_d = acc_shift_s;
            if (cnt_q == CNT_LAST) begin
               // MSB processed: publish result; counter only reloads on acceptance.
               res_d   = acc_shift_s;
               bo_d    = fs_bo_s;
               state_d = SER_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = SER_SHIFT;
               busy_d  = 1'b1;
            end
         end

         SER_DONE: begin
            state_d = SER_IDLE;
         end

         default: begin
            state_d = SER_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SER_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         br_q    <= 1'b0;
         acc_q   <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         bo_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         bo_q    <= bo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign D    = res_q;
   assign Bo   = bo_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial at WIDTH=8.
module tb_subtractor_serial;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       Bi;
   logic       busy;
   logic       done;
   logic [7:0] D;
   logic       Bo;

   int n_cmp = 0;
   int n_err = 0;

   subtractor_serial #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bi    (Bi),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bo    (Bo)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands and a one-cycle start; returns in SHIFT cycle 1
   // with the inputs scrambled so late changes must not matter.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
      @(negedge clk);
      A = a; B = b; Bi = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = ~a; B = ~b; Bi = ~bi;
   endtask

   // Check 8 busy cycles with D held, then the done cycle with the result.
   // inj_k > 0 raises start (A=1,B=1) during that SHIFT cycle.
   task automatic expect_result(input string tag, input logic [7:0] exp_d, input logic exp_bo,
                                input logic [7:0] prev_d, input int inj_k);
      for (int k = 1; k <= 8; k++) begin
         chk({tag, "_busy"},   32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         chk({tag, "_hold"},   32'(D),    32'(prev_d));
         if (k == inj_k) begin
            start = 1'b1; A = 8'd1; B = 8'd1; Bi = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_done"},   32'(done), 32'd1);
      chk({tag, "_idlebz"}, 32'(busy), 32'd0);
      chk({tag, "_D"},      32'(D),    32'(exp_d));
      chk({tag, "_Bo"},     32'(Bo),   32'(exp_bo));
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbi;
      logic [8:0] m;
      logic [7:0] last_d;
      logic       saw_done;
      logic       saw_busy;

      rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0; Bi = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_D",    32'(D),    32'd0);
      chk("rst_Bo",   32'(Bo),   32'd0);
      rst = 1'b0;

      // Idle without start: nothing happens.
      repeat (3) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);

      // Basic operation, then back-to-back at minimum spacing.
      start_op(8'd100, 8'd37, 1'b0);
      expect_result("r100_37", 8'd63, 1'b0, 8'd0, 0);
      start_op(8'd5, 8'd9, 1'b0);
      expect_result("r5_9", 8'hFC, 1'b1, 8'd63, 0);
      start_op(8'd0, 8'd0, 1'b1);
      expect_result("r0_0_bi", 8'hFF, 1'b1, 8'hFC, 0);
      start_op(8'hFF, 8'hFF, 1'b0);
      expect_result("rff_ff", 8'h00, 1'b0, 8'hFF, 0);
      start_op(8'd200, 8'd55, 1'b1);
      expect_result("r200_55_bi", 8'h90, 1'b0, 8'h00, 0);
      start_op(8'h80, 8'h7F, 1'b1);
      expect_result("r80_7f_bi", 8'h00, 1'b0, 8'h90, 0);
      start_op(8'd0, 8'hFF, 1'b1);
      expect_result("r0_ff_bi", 8'h00, 1'b1, 8'h00, 0);
      start_op(8'hFF, 8'd0, 1'b1);
      expect_result("rff_0_bi", 8'hFE, 1'b0, 8'h00, 0);

      // Start during SHIFT cycle 3 is ignored and not queued.
      start_op(8'd100, 8'd37, 1'b0);
      expect_result("inject", 8'd63, 1'b0, 8'hFE, 3);
      @(negedge clk);
      chk("inject_noq_busy", 32'(busy), 32'd0);
      chk("inject_noq_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("inject_noq_busy2", 32'(busy), 32'd0);

      // Reset in SHIFT cycle 4 aborts the operation.
      start_op(8'd55, 8'd3, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_D",    32'(D),    32'd0);
      chk("abort_Bo",   32'(Bo),   32'd0);
      saw_done = 1'b0;
      saw_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         saw_done = saw_done | done;
         saw_busy = saw_busy | busy;
      end
      chk("abort_nodone", 32'(saw_done), 32'd0);
      chk("abort_nobusy", 32'(saw_busy), 32'd0);
      start_op(8'd9, 8'd4, 1'b0);
      expect_result("after_abort", 8'd5, 1'b0, 8'd0, 0);

      // Reset wins over start in the same cycle.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; A = 8'd9; B = 8'd1; Bi = 1'b0;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("prio_busy", 32'(busy), 32'd0);
      chk("prio_D",    32'(D),    32'd0);
      @(negedge clk);
      chk("prio_busy2", 32'(busy), 32'd0);

      // Back-to-back sweep with a 9-bit reference difference.
      last_d = 8'd0;
      for (int n = 0; n < 24; n++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rbi = 1'($urandom_range(0, 1));
         m   = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
         start_op(ra, rb, rbi);
         expect_result($sformatf("sweep%0d", n), m[7:0], m[8], last_d, 0);
         last_d = m[7:0];
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
